// File: rtl/cm_sort_net.sv
// cm_sort_net: pipelined bitonic sorter (unsigned, ascending) with latency REG_CNT.
// Define CM_SORT_DATA_RST_EN to give the data register ranks an asynchronous reset to 0.
module cm_sort_net #(
  parameter int DCNT    = 4,
  parameter int DWIDTH  = 16,
  parameter int REG_CNT = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_vld,
  input  logic [DCNT-1:0][DWIDTH-1:0] i_data,
  output logic                        o_vld,
  output logic [DCNT-1:0][DWIDTH-1:0] o_data
);

  localparam int LOG_P = $clog2(DCNT);
  localparam int P     = 1 << LOG_P;
  localparam int NSTG  = LOG_P * (LOG_P + 1) / 2;

  typedef logic [P-1:0][DWIDTH-1:0] lanes_t;

  // Boundary (number of network stages already applied) that rank k follows.
  function automatic int rankPos(input int k);
    return ((k + 1) * NSTG) / REG_CNT;
  endfunction

  function automatic int lastRankAt(input int m);
    int r;
    r = -1;
    for (int k = 0; k < REG_CNT; k++) begin
      if (rankPos(k) == m) r = k;
    end
    return r;
  endfunction

  wire lanes_t combLanes [0:NSTG];
  wire lanes_t postLanes [0:NSTG];
  wire lanes_t rankData_d [0:REG_CNT-1];
  lanes_t      rankData_q [0:REG_CNT-1];
  wire  [REG_CNT-1:0] rankVld_d;
  logic [REG_CNT-1:0] rankVld_q;

  // All-ones padding sinks to the top lanes, which are dropped at the output.
  for (genvar i = 0; i < P; i++) begin : gPadIn
    if (i < DCNT) begin : gReal
      assign combLanes[0][i] = i_data[i];
    end else begin : gPad
      assign combLanes[0][i] = '1;
    end
  end

  // Each boundary either passes straight through or is taken from its last rank.
  for (genvar m = 0; m <= NSTG; m++) begin : gBound
    localparam int LR = lastRankAt(m);
    if (LR >= 0) begin : gReg
      assign postLanes[m] = rankData_q[LR];
    end else begin : gThru
      assign postLanes[m] = combLanes[m];
    end
  end

  for (genvar a = 1; a <= LOG_P; a++) begin : gMerge
    for (genvar b = a; b >= 1; b--) begin : gStep
      localparam int STG = a * (a - 1) / 2 + (a - b);
      localparam int K   = 1 << a;
      localparam int J   = 1 << (b - 1);
      for (genvar i = 0; i < P; i++) begin : gLane
        if ((i & J) == 0) begin : gCe
          wire [DWIDTH-1:0] laneA = postLanes[STG][i];
          wire [DWIDTH-1:0] laneB = postLanes[STG][i + J];
          wire              swap  = ((i & K) == 0) ? (laneA > laneB) : (laneA < laneB);
          assign combLanes[STG+1][i]     = swap ? laneB : laneA;
          assign combLanes[STG+1][i + J] = swap ? laneA : laneB;
        end
      end
    end
  end

  // Ranks sharing a boundary form a plain delay chain behind the first one.
  for (genvar k = 0; k < REG_CNT; k++) begin : gRank
    if (k > 0 && rankPos(k - 1) == rankPos(k)) begin : gChain
      assign rankData_d[k] = rankData_q[k-1];
    end else begin : gTap
      assign rankData_d[k] = combLanes[rankPos(k)];
    end
    if (k == 0) begin : gVldIn
      assign rankVld_d[k] = i_vld;
    end else begin : gVldChain
      assign rankVld_d[k] = rankVld_q[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rankVld_q <= '0;
    end else begin
      rankVld_q <= rankVld_d;
    end
  end

`ifdef CM_SORT_DATA_RST_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < REG_CNT; k++) rankData_q[k] <= '0;
    end else begin
      for (int k = 0; k < REG_CNT; k++) rankData_q[k] <= rankData_d[k];
    end
  end
`else
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < REG_CNT; k++) rankData_q[k] <= rankData_d[k];
  end
`endif

  assign o_vld  = rankVld_q[REG_CNT-1];
  assign o_data = postLanes[NSTG][DCNT-1:0];

  if (P > DCNT) begin : gPadOut
    wire unusedPad = ^postLanes[NSTG][P-1:DCNT];
  end

endmodule

// File: tb/tb_cm_sort_net.sv
// Self-checking bench for cm_sort_net: four configurations share one input bus,
// each with its own valid strobe, checked against hand-computed or reference-sorted results.
module tb_cm_sort_net;

  logic              clk;
  logic              rst;
  logic [3:0]        vldIn;
  logic [9:0][15:0]  drvBus;
  wire  [3:0]        obsVld;
  logic [3:0][15:0]  out4;
  logic [5:0][15:0]  out6;
  logic [9:0][15:0]  out10;
  logic [7:0][15:0]  out8;
  logic [9:0][15:0]  vecs  [0:7];
  logic [255:0]      expPk [0:7];
  int                testsRun;
  int                testsFailed;

  cm_sort_net #(.DCNT(4), .DWIDTH(16), .REG_CNT(1)) u4 (
    .i_clk(clk), .i_rst(rst), .i_vld(vldIn[0]), .i_data(drvBus[3:0]),
    .o_vld(obsVld[0]), .o_data(out4));

  cm_sort_net #(.DCNT(6), .DWIDTH(16), .REG_CNT(2)) u6 (
    .i_clk(clk), .i_rst(rst), .i_vld(vldIn[1]), .i_data(drvBus[5:0]),
    .o_vld(obsVld[1]), .o_data(out6));

  cm_sort_net #(.DCNT(10), .DWIDTH(16), .REG_CNT(4)) u10 (
    .i_clk(clk), .i_rst(rst), .i_vld(vldIn[2]), .i_data(drvBus),
    .o_vld(obsVld[2]), .o_data(out10));

  cm_sort_net #(.DCNT(8), .DWIDTH(16), .REG_CNT(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_vld(vldIn[3]), .i_data(drvBus[7:0]),
    .o_vld(obsVld[3]), .o_data(out8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] obsData(input int inst);
    logic [255:0] r;
    r = '0;
    case (inst)
      0:       r[63:0]  = out4;
      1:       r[95:0]  = out6;
      2:       r[159:0] = out10;
      default: r[127:0] = out8;
    endcase
    return r;
  endfunction

  // Reference model: insertion sort of the first n elements.
  function automatic logic [255:0] refSort(input logic [9:0][15:0] v, input int n);
    logic [15:0]  a [0:9];
    logic [15:0]  t;
    logic [255:0] r;
    for (int i = 0; i < 10; i++) a[i] = v[i];
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0; j--) begin
        if (a[j-1] > a[j]) begin
          t = a[j-1]; a[j-1] = a[j]; a[j] = t;
        end
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r[i*16 +: 16] = a[i];
    return r;
  endfunction

  // Streams vecs[0..nv-1] back to back into one instance and checks every cycle.
  task automatic applyStimulus(input int inst, input int lat, input int nv, input string tag);
    int idx;
    for (int c = 0; c < nv + lat; c++) begin
      if (c < nv) begin
        drvBus      = vecs[c];
        vldIn[inst] = 1'b1;
      end else begin
        vldIn[inst] = 1'b0;
      end
      @(posedge clk); #1;
      idx = c + 1 - lat;
      if (idx >= 0 && idx < nv) begin
        checkOutput({tag, "_vld"}, obsVld[inst], 1);
        checkOutput({tag, "_data"}, obsData(inst), expPk[idx]);
      end else begin
        checkOutput({tag, "_vld"}, obsVld[inst], 0);
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    vldIn       = '0;
    drvBus      = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_vld", obsVld, 0);
`ifdef CM_SORT_DATA_RST_EN
    for (int i = 0; i < 4; i++) checkOutput("reset_data", obsData(i), 0);
`endif
    rst = 1'b0;

    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      checkOutput("idle_vld", obsVld, 0);
`ifdef CM_SORT_DATA_RST_EN
      for (int i = 0; i < 4; i++) checkOutput("idle_data", obsData(i), 0);
`endif
    end

    vecs[0] = '0;
    vecs[0][0] = 16'd7; vecs[0][1] = 16'd3; vecs[0][2] = 16'd9; vecs[0][3] = 16'd1;
    expPk[0] = 256'({16'd9, 16'd7, 16'd3, 16'd1});
    applyStimulus(0, 1, 1, "sort4");

    vecs[0] = '0;
    vecs[0][0] = 16'hFFFF; vecs[0][1] = 16'd5; vecs[0][2] = 16'd0;
    vecs[0][3] = 16'h8000; vecs[0][4] = 16'd5; vecs[0][5] = 16'd2;
    expPk[0] = 256'({16'hFFFF, 16'h8000, 16'd5, 16'd5, 16'd2, 16'd0});
    applyStimulus(1, 2, 1, "sort6pad");

    vecs[0] = '0;
    for (int e = 0; e < 8; e++) vecs[0][e] = 16'(7 - e);
    expPk[0] = 256'({16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0});
    applyStimulus(3, 8, 1, "sort8desc");

    for (int v = 0; v < 8; v++) begin
      for (int e = 0; e < 10; e++) begin
        case (v)
          5:       vecs[v][e] = 16'($urandom_range(0, 3));
          6:       vecs[v][e] = (e % 3 == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
          7:       vecs[v][e] = 16'h1234;
          default: vecs[v][e] = 16'($urandom_range(0, 65535));
        endcase
      end
      expPk[v] = refSort(vecs[v], 10);
    end
    applyStimulus(2, 4, 8, "sort10stream");

    drvBus = vecs[0];
    vldIn  = 4'b0101;
    @(posedge clk); #1;
    vldIn  = '0;
    checkOutput("rstPre_vld", obsVld[0], 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstDrop_vld", obsVld, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput("rstFlush_vld", obsVld, 0);
    end

    vecs[0]  = '0;
    expPk[0] = '0;
    for (int e = 0; e < 10; e++) begin
      vecs[0][e]           = 16'((e * 7) % 10);
      expPk[0][e*16 +: 16] = 16'(e);
    end
    applyStimulus(2, 4, 1, "sort10postRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
